router_dest_reader: RTL and testbench

Destination-side packet reader for one output port of the 1x3 router. It watches the port's valid flag, drives the port's read enable, and pulls header, payload and parity bytes out of the output FIFO. It checks packet length, port address and parity, then reports each packet with a done or drop pulse. One instance sits on each of ports 0, 1 and 2, acting as the consumer for the write-side synchroniser and FIFO.

---
 rtl/router_pkg.sv | 17 +
 rtl/router_parity_acc.sv | 35 +++
 rtl/router_dest_reader.sv | 186 ++++++++++++++++++
 tb/tb_router_dest_reader.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: header field positions, address width,
// soft-reset timeout and the destination-reader FSM state type.
package router_pkg;

  localparam int unsigned HDR_LEN_MSB      = 7;
  localparam int unsigned HDR_LEN_LSB      = 2;
  localparam int unsigned ADDR_W           = 2;
  localparam int unsigned SOFT_RST_TIMEOUT = 30;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    READ  = 2'd2,
    CHECK = 2'd3
  } rd_state_e;

endpackage

// File: rtl/router_parity_acc.sv
// 8-bit XOR parity accumulator, shared by source- and destination-side logic.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   clr_i      : clear accumulator to 0 (highest priority)
//   seed_i     : load accumulator with data_i
//   acc_i      : XOR data_i into accumulator
//   data_i     : byte to seed or accumulate
//   par_o      : current accumulated parity
module router_parity_acc (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       seed_i,
  input  logic       acc_i,
  input  logic [7:0] data_i,
  output logic [7:0] par_o
);

  logic [7:0] par_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= 8'h00;
    end else if (clr_i) begin
      par_q <= 8'h00;
    end else if (seed_i) begin
      par_q <= data_i;
    end else if (acc_i) begin
      par_q <= par_q ^ data_i;
    end
  end

  assign par_o = par_q;

endmodule

// File: rtl/router_dest_reader.sv
// Destination-side packet reader for one router output port. Pulls header,
// payload and parity bytes from the port FIFO, streams the payload, checks
// address and parity, and reports each packet with pkt_done or pkt_drop.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   vld_out      : port FIFO non-empty
//   data_out     : FIFO read data, valid the cycle after a sampled read_enb
//   soft_reset   : router flush of this port
//   read_enb     : FIFO read request (combinational, gated by soft_reset)
//   byte_valid   : byte_data carries a payload byte
//   byte_data    : payload byte
//   pkt_done     : one-cycle pulse, packet fully read
//   pkt_len      : payload length of the last header
//   parity_err   : with pkt_done, parity mismatch
//   addr_err     : with pkt_done, header address is not PORT_ID
//   pkt_drop     : one-cycle pulse, packet aborted by soft_reset
module router_dest_reader
  import router_pkg::*;
#(
  parameter int unsigned PORT_ID  = 0,
  parameter int unsigned RD_DELAY = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vld_out,
  input  logic [7:0] data_out,
  input  logic       soft_reset,
  output logic       read_enb,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       pkt_done,
  output logic [5:0] pkt_len,
  output logic       parity_err,
  output logic       addr_err,
  output logic       pkt_drop
);

  localparam int unsigned CNT_W = 7;
  localparam int unsigned DLY_W = 6;

  rd_state_e         state_q;
  logic [DLY_W-1:0]  dly_q;
  logic [CNT_W-1:0]  issued_q;
  logic [CNT_W-1:0]  rcvd_q;
  logic [CNT_W-1:0]  total_q;
  logic              rd_pend_q;
  logic [ADDR_W-1:0] addr_q;
  logic [5:0]        pkt_len_q;
  logic              byte_valid_q;
  logic [7:0]        byte_data_q;
  logic              pkt_done_q;
  logic              parity_err_q;
  logic              addr_err_q;
  logic              pkt_drop_q;

  logic [5:0] hdr_len;
  logic       in_read;
  logic       hdr_byte;
  logic       par_byte;
  logic       pay_byte;
  logic [7:0] par_acc;

  assign hdr_len = data_out[HDR_LEN_MSB:HDR_LEN_LSB];

  // Reads stop once issued reaches total, so the next header stays in the FIFO.
  assign read_enb = (state_q == READ) && vld_out && (issued_q < total_q) && !soft_reset;

  // Byte classification of the data returned for the previous read.
  assign in_read  = (state_q == READ) && !soft_reset;
  assign hdr_byte = rd_pend_q && (rcvd_q == '0);
  assign par_byte = rd_pend_q && (rcvd_q != '0) && (rcvd_q == total_q - 7'd1);
  assign pay_byte = rd_pend_q && (rcvd_q != '0) && !par_byte;

  router_parity_acc u_parity_acc (
    .clk    (clk),
    .rst    (reset),
    .clr_i  (state_q == IDLE),
    .seed_i (in_read && hdr_byte),
    .acc_i  (in_read && pay_byte),
    .data_i (data_out),
    .par_o  (par_acc)
  );

  // Reader FSM with registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      dly_q        <= '0;
      issued_q     <= '0;
      rcvd_q       <= '0;
      total_q      <= '0;
      rd_pend_q    <= 1'b0;
      addr_q       <= '0;
      pkt_len_q    <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      pkt_done_q   <= 1'b0;
      parity_err_q <= 1'b0;
      addr_err_q   <= 1'b0;
      pkt_drop_q   <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      pkt_done_q   <= 1'b0;
      parity_err_q <= 1'b0;
      addr_err_q   <= 1'b0;
      pkt_drop_q   <= 1'b0;
      rd_pend_q    <= read_enb;

      case (state_q)
        IDLE: begin
          issued_q <= '0;
          rcvd_q   <= '0;
          total_q  <= 7'd127;
          if (vld_out) begin
            if (RD_DELAY == 0) begin
              state_q <= READ;
            end else begin
              dly_q   <= DLY_W'(RD_DELAY);
              state_q <= DELAY;
            end
          end
        end

        DELAY: begin
          if (soft_reset) begin
            pkt_drop_q <= 1'b1;
            state_q    <= IDLE;
          end else begin
            dly_q <= dly_q - 6'd1;
            if (dly_q <= 6'd1) begin
              state_q <= READ;
            end
          end
        end

        READ: begin
          if (soft_reset) begin
            // Abort: any byte still in flight is discarded.
            pkt_drop_q <= 1'b1;
            rd_pend_q  <= 1'b0;
            state_q    <= IDLE;
          end else begin
            if (read_enb) begin
              issued_q <= issued_q + 7'd1;
            end
            if (rd_pend_q) begin
              rcvd_q <= rcvd_q + 7'd1;
            end
            if (hdr_byte) begin
              pkt_len_q <= hdr_len;
              addr_q    <= data_out[ADDR_W-1:0];
              total_q   <= CNT_W'(hdr_len) + 7'd2;
            end
            if (pay_byte) begin
              byte_valid_q <= 1'b1;
              byte_data_q  <= data_out;
            end
            if (par_byte) begin
              pkt_done_q   <= 1'b1;
              parity_err_q <= (par_acc != data_out);
              addr_err_q   <= (addr_q != ADDR_W'(PORT_ID));
              state_q      <= CHECK;
            end
          end
        end

        CHECK: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign pkt_done   = pkt_done_q;
  assign pkt_len    = pkt_len_q;
  assign parity_err = parity_err_q;
  assign addr_err   = addr_err_q;
  assign pkt_drop   = pkt_drop_q;

endmodule

// File: tb/tb_router_dest_reader.sv
// Bench for router_dest_reader: a FIFO model feeds instance A (PORT_ID 1,
// no delay) with directed and random packets checked against a packet-level
// model; instance B (RD_DELAY 40) exercises the delay and soft_reset paths.
module tb_router_dest_reader;
  import router_pkg::*;

  localparam int unsigned PORT_A = 1;
  localparam int unsigned DLY_B  = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  // instance A
  logic       vld_a, srst_a, stall_a;
  logic [7:0] data_a;
  logic       rd_a, bv_a, done_a, perr_a, aerr_a, drop_a;
  logic [7:0] bd_a;
  logic [5:0] pl_a;
  // instance B
  logic       vld_b, srst_b;
  logic [7:0] data_b;
  logic       rd_b, bv_b, done_b, perr_b, aerr_b, drop_b;
  logic [7:0] bd_b;
  logic [5:0] pl_b;

  // FIFO model for A
  logic [7:0] fq[$];
  int         fcnt;
  logic       rd_seen_a;
  assign vld_a = (fcnt != 0) && !stall_a;

  // Packet-level expectations
  logic [5:0] exp_len[$];
  logic       exp_perr[$];
  logic       exp_aerr[$];
  logic [7:0] exp_bytes[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_reads = 0;
  int n_got = 0;
  int last_rd = 0;

  router_dest_reader #(.PORT_ID(PORT_A), .RD_DELAY(0)) u_dut_a (
    .clk(clk), .reset(reset), .vld_out(vld_a), .data_out(data_a),
    .soft_reset(srst_a), .read_enb(rd_a), .byte_valid(bv_a), .byte_data(bd_a),
    .pkt_done(done_a), .pkt_len(pl_a), .parity_err(perr_a), .addr_err(aerr_a),
    .pkt_drop(drop_a)
  );

  router_dest_reader #(.PORT_ID(PORT_A), .RD_DELAY(DLY_B)) u_dut_b (
    .clk(clk), .reset(reset), .vld_out(vld_b), .data_out(data_b),
    .soft_reset(srst_b), .read_enb(rd_b), .byte_valid(bv_b), .byte_data(bd_b),
    .pkt_done(done_b), .pkt_len(pl_b), .parity_err(perr_b), .addr_err(aerr_b),
    .pkt_drop(drop_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    fq.push_back(b);
    fcnt = fq.size();
  endtask

  // mode 1: payload 0x11,0x22,...; bad 0: good parity, 1: parity 0x00, 2: one bit flipped
  task automatic send_pkt(input logic [5:0] len, input logic [1:0] addr, input int mode, input int bad);
    logic [7:0] hdr, b, par, sent;
    hdr = {len, addr};
    par = hdr;
    push_byte(hdr);
    for (int i = 0; i < int'(len); i++) begin
      b = (mode == 1) ? 8'((i + 1) * 17) : 8'($urandom);
      par ^= b;
      push_byte(b);
      exp_bytes.push_back(b);
    end
    if (bad == 1)      sent = 8'h00;
    else if (bad == 2) sent = par ^ (8'h01 << $urandom_range(0, 7));
    else               sent = par;
    push_byte(sent);
    exp_len.push_back(len);
    exp_perr.push_back(sent != par);
    exp_aerr.push_back(addr != 2'(PORT_A));
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (exp_len.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk(tag, 32'(exp_len.size()), 0);
    chk({tag, "_fifo"}, 32'(fcnt), 0);
    @(posedge clk);
    #2;
  endtask

  // FIFO pop: data appears the cycle after a sampled read
  always @(posedge clk) begin
    #1;
    if (rd_seen_a && fq.size() != 0) begin
      data_a = fq.pop_front();
      fcnt = fq.size();
    end
  end

  // Monitor for A, sampled mid-cycle
  always @(negedge clk) begin
    logic [5:0] l;
    logic pe, ae;
    cyc++;
    rd_seen_a = rd_a;
    if (reset) begin
      n_reads = 0;
      n_got = 0;
    end else begin
      if (rd_a) begin
        chk("read_nonempty", 32'(fcnt != 0), 1);
        n_reads++;
        last_rd = cyc;
      end
      if (bv_a) begin
        if (exp_bytes.size() == 0) chk("extra_byte", 32'(bv_a), 0);
        else begin
          chk("payload_byte", 32'(bd_a), 32'(exp_bytes.pop_front()));
          n_got++;
        end
      end
      if (done_a) begin
        if (exp_len.size() == 0) chk("spurious_done", 32'(done_a), 0);
        else begin
          l  = exp_len.pop_front();
          pe = exp_perr.pop_front();
          ae = exp_aerr.pop_front();
          chk("pkt_len", 32'(pl_a), 32'(l));
          chk("parity_err", 32'(perr_a), 32'(pe));
          chk("addr_err", 32'(aerr_a), 32'(ae));
          chk("reads_per_pkt", 32'(n_reads), 32'(l) + 2);
          chk("bytes_per_pkt", 32'(n_got), 32'(l));
          chk("done_latency", 32'(cyc - last_rd), 2);
        end
        n_reads = 0;
        n_got = 0;
      end
      if (drop_a) chk("a_unexpected_drop", 32'(drop_a), 0);
    end
  end

  initial begin
    int lat;
    bit got;
    reset = 1'b1; srst_a = 1'b0; stall_a = 1'b0; data_a = 8'h00; fcnt = 0;
    vld_b = 1'b0; srst_b = 1'b0; data_b = 8'h00; rd_seen_a = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_read_enb", 32'(rd_a), 0);
    chk("rst_byte_valid", 32'(bv_a), 0);
    chk("rst_byte_data", 32'(bd_a), 0);
    chk("rst_pkt_done", 32'(done_a), 0);
    chk("rst_pkt_len", 32'(pl_a), 0);
    chk("rst_errs", 32'({perr_a, aerr_a, drop_a}), 0);
    chk("rst_b", 32'({rd_b, drop_b}), 0);
    @(posedge clk); #2 reset = 1'b0;

    // B: soft_reset at the 30th DELAY cycle, no read ever
    @(posedge clk); #2 vld_b = 1'b1;
    @(posedge clk);
    for (int i = 1; i < int'(SOFT_RST_TIMEOUT); i++) begin
      @(negedge clk);
      chk("b_delay_no_read", 32'(rd_b), 0);
      @(posedge clk);
    end
    #2 srst_b = 1'b1; vld_b = 1'b0;
    @(negedge clk); chk("b_srst_no_read", 32'(rd_b), 0);
    @(posedge clk); #2 srst_b = 1'b0;
    @(negedge clk); chk("b_drop_pulse", 32'(drop_b), 1);
    @(negedge clk); chk("b_drop_one_cycle", 32'(drop_b), 0);

    // B: first-read latency, then soft_reset while reading
    @(posedge clk); #2 vld_b = 1'b1;
    @(posedge clk);
    lat = 0; got = 0;
    while (!got && lat < 100) begin
      @(negedge clk);
      lat++;
      if (rd_b) got = 1;
    end
    chk("b_first_read_lat", 32'(lat), DLY_B + 1);
    #1 srst_b = 1'b1;
    #1 chk("b_srst_gates_read", 32'(rd_b), 0);
    @(posedge clk); #2 srst_b = 1'b0; vld_b = 1'b0;
    @(negedge clk);
    chk("b_drop_in_read", 32'(drop_b), 1);
    chk("b_quiet", 32'({bv_b, done_b, perr_b, aerr_b, |bd_b, |pl_b}), 0);

    // A directed
    @(posedge clk); #2 send_pkt(6'd4, 2'd1, 1, 0); wait_drain("t_good", 200);
    send_pkt(6'd4, 2'd1, 1, 1); wait_drain("t_bad_par", 200);
    send_pkt(6'd4, 2'd2, 1, 0); wait_drain("t_bad_addr", 200);
    send_pkt(6'd0, 2'd1, 0, 0); send_pkt(6'd3, 2'd1, 0, 0); wait_drain("t_len0_b2b", 200);

    send_pkt(6'd8, 2'd1, 0, 0);
    repeat (4) @(posedge clk);
    #2 stall_a = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_no_read", 32'(rd_a), 0);
    end
    @(posedge clk); #2 stall_a = 1'b0;
    wait_drain("t_stall", 200);

    // A random packets with random FIFO stalls
    for (int p = 0; p < 16; p++)
      send_pkt(6'($urandom_range(0, 12)), 2'($urandom_range(0, 3)), 0,
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
    for (int n = 0; n < 3000 && exp_len.size() != 0; n++) begin
      @(posedge clk);
      #2 stall_a = ($urandom_range(0, 4) == 0);
    end
    stall_a = 1'b0;
    wait_drain("t_random", 200);

    // A: reset during READ clears outputs immediately
    push_byte(8'h29);
    for (int i = 0; i < 11; i++) push_byte(8'($urandom));
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rd_a && lat < 50);
    chk("a_read_started", 32'(rd_a), 1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_read_enb", 32'(rd_a), 0);
    chk("mid_rst_byte", 32'({bv_a, bd_a}), 0);
    chk("mid_rst_done", 32'(done_a), 0);
    chk("mid_rst_pkt_len", 32'(pl_a), 0);
    chk("mid_rst_errs", 32'({perr_a, aerr_a, drop_a}), 0);
    fq.delete();
    fcnt = 0;
    @(posedge clk); #2 reset = 1'b0;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
